// File: rtl/jtdd_obj_rom_slot_pkg.sv
// Shared definitions for the OBJ ROM slot.
//  - fetch_state_t : SDRAM fetch sequencer encoding (IDLE/REQ/WAIT/FILL)
//  - word order of a fetched 32-bit line: even word in the low half,
//    odd word in the high half
//  - pick_word()   : selects the 16-bit word of a line from addr[0]
package jtdd_obj_rom_slot_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_FILL = 2'd3
  } fetch_state_t;

  localparam int WORD_W    = 16;
  localparam int LINE_W    = 32;
  localparam int EVEN_LSB  = 0;
  localparam int ODD_LSB   = 16;
  localparam int NUM_LINES = 2;

  function automatic logic [WORD_W-1:0] pick_word(input logic [LINE_W-1:0] line,
                                                  input logic              odd);
    return odd ? line[ODD_LSB +: WORD_W] : line[EVEN_LSB +: WORD_W];
  endfunction

endpackage

// File: rtl/jtdd_obj_rom_slot_if.sv
// SDRAM arbiter port of the OBJ ROM slot.
//  master : the slot (drives sdram_req/sdram_addr, receives ack and data)
//  slave  : the arbiter side
//  sdram_req  - fetch request, held until sdram_ack
//  sdram_addr - 32-bit aligned SDRAM word address of the line
//  sdram_ack  - request accepted (1-cycle pulse)
//  data_rdy   - data_read valid (1-cycle pulse)
//  data_read  - fetched line, [15:0] even word, [31:16] odd word
interface jtdd_obj_rom_slot_if #(
  parameter int SDW = 22
);
  logic           sdram_req;
  logic [SDW-1:0] sdram_addr;
  logic           sdram_ack;
  logic           data_rdy;
  logic [31:0]    data_read;

  modport master (
    output sdram_req, sdram_addr,
    input  sdram_ack, data_rdy, data_read
  );

  modport slave (
    input  sdram_req, sdram_addr,
    output sdram_ack, data_rdy, data_read
  );
endinterface

// File: rtl/jtdd_obj_rom_slot_line.sv
// One cache line of the OBJ ROM slot: valid bit, tag and 32-bit data.
//  clk/rst  : clock, synchronous active-high reset
//  clr      : invalidate the line (ROM download)
//  wr_en    : load wr_tag/wr_data and mark valid
//  rd_tag   : tag of the consumer address, rd_odd selects the word
//  hit      : line valid and tag matches rd_tag
//  word     : selected 16-bit word of the stored line
//  valid/tag: stored state, used by the victim choice in the top
module jtdd_rom_line
  import jtdd_obj_rom_slot_pkg::*;
#(
  parameter int TW = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [TW-1:0]     wr_tag,
  input  logic [LINE_W-1:0] wr_data,
  input  logic [TW-1:0]     rd_tag,
  input  logic              rd_odd,
  output logic              hit,
  output logic [WORD_W-1:0] word,
  output logic              valid,
  output logic [TW-1:0]     tag
);
  logic              valid_reg;
  logic [TW-1:0]     tag_reg;
  logic [LINE_W-1:0] data_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= 1'b0;
      tag_reg   <= '0;
      data_reg  <= '0;
    end else if (clr) begin
      valid_reg <= 1'b0;
    end else if (wr_en) begin
      valid_reg <= 1'b1;
      tag_reg   <= wr_tag;
      data_reg  <= wr_data;
    end
  end

  assign hit   = valid_reg && (tag_reg == rd_tag);
  assign word  = pick_word(data_reg, rd_odd);
  assign valid = valid_reg;
  assign tag   = tag_reg;
endmodule

// File: rtl/jtdd_obj_rom_slot.sv
// OBJ layer ROM slot: serves 16-bit words to the sprite engine from a
// 2-line cache of 32-bit lines and fetches misses from SDRAM.
//  clk, rst     : clock, synchronous active-high reset
//  downloading  : ROM load in progress - invalidate cache, abort fetch
//  cs, addr     : consumer request and word address
//  dout, ok     : word for addr; ok only while addr still equals the
//                 address dout was loaded for
//  sdram        : arbiter port (req/addr out, ack/data_rdy/data_read in)
module jtdd_obj_rom_slot
  import jtdd_obj_rom_slot_pkg::*;
#(
  parameter int           AW     = 18,
  parameter int           SDW    = 22,
  parameter logic [SDW-1:0] OFFSET = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              downloading,
  input  logic              cs,
  input  logic [AW-1:0]     addr,
  output logic [WORD_W-1:0] dout,
  output logic              ok,
  jtdd_obj_rom_slot_if.master sdram
);
  localparam int TW = AW - 1;

  fetch_state_t      state_reg, state_next;
  logic              req_reg;
  logic [SDW-1:0]    sdram_addr_reg;
  logic [TW-1:0]     inflight_tag_reg;
  logic              victim_reg;
  logic [WORD_W-1:0] dout_reg;
  logic              ok_reg;
  logic [AW-1:0]     addr_reg;

  logic [TW-1:0]     cur_tag;
  logic              line_hit   [NUM_LINES];
  logic [WORD_W-1:0] line_word  [NUM_LINES];
  logic              line_valid [NUM_LINES];
  logic [TW-1:0]     line_tag   [NUM_LINES];
  logic              hit_any;
  logic [WORD_W-1:0] hit_word;
  logic              victim_sel;
  logic              data_take;
  logic              start_fetch;
  logic [SDW-1:0]    fetch_offset;

  assign cur_tag  = addr[AW-1:1];
  assign hit_any  = line_hit[0] | line_hit[1];
  assign hit_word = line_hit[1] ? line_word[1] : line_word[0];

  // Round-robin victim, but skip a line that already holds the in-flight
  // tag so a fill never leaves two copies of the same line.
  assign victim_sel = (line_valid[victim_reg] && line_tag[victim_reg] == inflight_tag_reg)
                      ? ~victim_reg : victim_reg;

  // data_rdy is accepted in WAIT, or in REQ when it arrives together with
  // the ack; anywhere else it belongs to an aborted fetch and is dropped.
  assign data_take = sdram.data_rdy && !downloading &&
                     ((state_reg == ST_WAIT) || (state_reg == ST_REQ && sdram.sdram_ack));

  assign fetch_offset = {{(SDW-AW){1'b0}}, addr[AW-1:1], 1'b0};

  generate
    for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_line
      jtdd_rom_line #(.TW(TW)) u_line (
        .clk     (clk),
        .rst     (rst),
        .clr     (downloading),
        .wr_en   (data_take && (victim_sel == 1'(gi))),
        .wr_tag  (inflight_tag_reg),
        .wr_data (sdram.data_read),
        .rd_tag  (cur_tag),
        .rd_odd  (addr[0]),
        .hit     (line_hit[gi]),
        .word    (line_word[gi]),
        .valid   (line_valid[gi]),
        .tag     (line_tag[gi])
      );
    end
  endgenerate

  always_comb begin
    state_next  = state_reg;
    start_fetch = 1'b0;
    if (downloading) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (cs && !hit_any) begin
            state_next  = ST_REQ;
            start_fetch = 1'b1;
          end
        end
        ST_REQ: begin
          if (sdram.sdram_ack) state_next = sdram.data_rdy ? ST_FILL : ST_WAIT;
        end
        ST_WAIT: begin
          if (sdram.data_rdy) state_next = ST_FILL;
        end
        ST_FILL: state_next = ST_IDLE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= ST_IDLE;
      req_reg          <= 1'b0;
      sdram_addr_reg   <= '0;
      inflight_tag_reg <= '0;
      victim_reg       <= 1'b0;
      dout_reg         <= '0;
      ok_reg           <= 1'b0;
      addr_reg         <= '0;
    end else begin
      state_reg <= state_next;

      if (downloading) begin
        req_reg <= 1'b0;
      end else if (start_fetch) begin
        req_reg          <= 1'b1;
        sdram_addr_reg   <= OFFSET + fetch_offset;
        inflight_tag_reg <= cur_tag;
      end else if (state_reg == ST_REQ && sdram.sdram_ack) begin
        req_reg <= 1'b0;
      end

      if (data_take) victim_reg <= ~victim_sel;

      // Hits are served in every state, so the line filled in FILL is
      // picked up on the FILL edge and ok rises one cycle later.
      if (downloading || !cs) begin
        ok_reg <= 1'b0;
      end else if (hit_any) begin
        dout_reg <= hit_word;
        ok_reg   <= 1'b1;
        addr_reg <= addr;
      end else begin
        ok_reg <= 1'b0;
      end
    end
  end

  assign sdram.sdram_req  = req_reg;
  assign sdram.sdram_addr = sdram_addr_reg;
  assign dout             = dout_reg;
  // Combinational gate: a new address drops ok in the same cycle.
  assign ok               = ok_reg && cs && (addr == addr_reg);
endmodule

// File: tb/tb_jtdd_obj_rom_slot.sv
module tb_jtdd_obj_rom_slot;
  logic        clk = 1'b0;
  logic        rst;
  logic        downloading, cs;
  logic [17:0] addr;
  logic [15:0] dout;
  logic        ok;
  logic        downloading1, cs1;
  logic [17:0] addr1;
  logic [15:0] dout1;
  logic        ok1;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  jtdd_obj_rom_slot_if #(.SDW(22)) bus0 ();
  jtdd_obj_rom_slot_if #(.SDW(22)) bus1 ();

  jtdd_obj_rom_slot #(.AW(18), .SDW(22), .OFFSET(22'h0)) dut0 (
    .clk(clk), .rst(rst), .downloading(downloading), .cs(cs), .addr(addr),
    .dout(dout), .ok(ok), .sdram(bus0.master)
  );

  jtdd_obj_rom_slot #(.AW(18), .SDW(22), .OFFSET(22'h10_0000)) dut1 (
    .clk(clk), .rst(rst), .downloading(downloading1), .cs(cs1), .addr(addr1),
    .dout(dout1), .ok(ok1), .sdram(bus1.master)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Arbiter: ack after ack_dly cycles in REQ, data after dat_dly cycles in WAIT.
  // Returns in the FILL cycle.
  task automatic serve(input int ack_dly, input int dat_dly, input logic [31:0] d);
    repeat (ack_dly - 1) tick();
    bus0.sdram_ack = 1'b1;
    tick();
    bus0.sdram_ack = 1'b0;
    repeat (dat_dly - 1) tick();
    bus0.data_rdy  = 1'b1;
    bus0.data_read = d;
    tick();
    bus0.data_rdy  = 1'b0;
    $display("serve line=%h ack_dly=%0d dat_dly=%0d", d, ack_dly, dat_dly);
  endtask

  initial begin
    rst = 1'b1; downloading = 1'b0; cs = 1'b0; addr = '0;
    downloading1 = 1'b0; cs1 = 1'b0; addr1 = '0;
    bus0.sdram_ack = 1'b0; bus0.data_rdy = 1'b0; bus0.data_read = '0;
    bus1.sdram_ack = 1'b0; bus1.data_rdy = 1'b0; bus1.data_read = '0;
    repeat (3) tick();
    check("rst_dout", dout, 16'h0);
    check("rst_ok", ok, 1'b0);
    check("rst_req", bus0.sdram_req, 1'b0);
    check("rst_saddr", bus0.sdram_addr, 22'h0);
    rst = 1'b0;

    // 1. cold miss
    cs = 1'b1; addr = 18'h00010;
    tick();
    check("t1_req", bus0.sdram_req, 1'b1);
    check("t1_saddr", bus0.sdram_addr, 22'h000010);
    check("t1_ok_req", ok, 1'b0);
    serve(2, 4, 32'hBEEF_1234);
    check("t1_ok_fill", ok, 1'b0);
    check("t1_req_fill", bus0.sdram_req, 1'b0);
    tick();
    check("t1_ok", ok, 1'b1);
    check("t1_dout", dout, 16'h1234);

    // 2. hit on odd word
    addr = 18'h00011;
    #1;
    check("t2_ok_change", ok, 1'b0);
    tick();
    check("t2_ok", ok, 1'b1);
    check("t2_dout", dout, 16'hBEEF);
    check("t2_noreq", bus0.sdram_req, 1'b0);

    // 3. address change during WAIT
    addr = 18'h00020;
    tick();
    check("t3_req", bus0.sdram_req, 1'b1);
    check("t3_saddr", bus0.sdram_addr, 22'h000020);
    bus0.sdram_ack = 1'b1;
    tick();
    bus0.sdram_ack = 1'b0;
    addr = 18'h00030;
    #1;
    check("t3_ok_wait", ok, 1'b0);
    tick();
    bus0.data_rdy = 1'b1; bus0.data_read = 32'hAAAA_2020;
    tick();
    bus0.data_rdy = 1'b0;
    check("t3_ok_fill", ok, 1'b0);
    tick();
    check("t3_ok_idle", ok, 1'b0);
    check("t3_req_idle", bus0.sdram_req, 1'b0);
    tick();
    check("t3_req2", bus0.sdram_req, 1'b1);
    check("t3_saddr2", bus0.sdram_addr, 22'h000030);
    serve(1, 1, 32'h3333_3030);
    tick();
    check("t3_ok30", ok, 1'b1);
    check("t3_dout30", dout, 16'h3030);
    addr = 18'h00020;
    #1;
    check("t3_ok_chg20", ok, 1'b0);
    tick();
    check("t3_ok20", ok, 1'b1);
    check("t3_dout20", dout, 16'h2020);

    // 4. replacement: 0x10 was evicted by 0x30
    addr = 18'h00010;
    tick();
    check("t4_req10", bus0.sdram_req, 1'b1);
    check("t4_saddr10", bus0.sdram_addr, 22'h000010);
    serve(1, 2, 32'hBEEF_1234);
    tick();
    check("t4_dout10", dout, 16'h1234);
    addr = 18'h00031;
    tick();
    check("t4_ok31", ok, 1'b1);
    check("t4_dout31", dout, 16'h3333);
    check("t4_noreq31", bus0.sdram_req, 1'b0);

    // 5. downloading during WAIT
    addr = 18'h00040;
    tick();
    check("t5_req", bus0.sdram_req, 1'b1);
    bus0.sdram_ack = 1'b1;
    tick();
    bus0.sdram_ack = 1'b0;
    downloading = 1'b1; cs = 1'b0;
    tick();
    downloading = 1'b0;
    check("t5_ok_dl", ok, 1'b0);
    check("t5_req_dl", bus0.sdram_req, 1'b0);
    bus0.data_rdy = 1'b1; bus0.data_read = 32'hDEAD_DEAD;
    tick();
    bus0.data_rdy = 1'b0;
    check("t5_req_late", bus0.sdram_req, 1'b0);
    cs = 1'b1; addr = 18'h00010;
    tick();
    check("t5_refetch", bus0.sdram_req, 1'b1);
    check("t5_saddr", bus0.sdram_addr, 22'h000010);
    // ack and data in the same cycle
    bus0.sdram_ack = 1'b1; bus0.data_rdy = 1'b1; bus0.data_read = 32'h5555_6666;
    tick();
    bus0.sdram_ack = 1'b0; bus0.data_rdy = 1'b0;
    tick();
    check("t5_ok", ok, 1'b1);
    check("t5_dout", dout, 16'h6666);

    // reset mid-fetch
    addr = 18'h00050;
    tick();
    check("rm_req", bus0.sdram_req, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0; cs = 1'b0;
    check("rm_req_rst", bus0.sdram_req, 1'b0);
    check("rm_saddr_rst", bus0.sdram_addr, 22'h0);
    check("rm_dout_rst", dout, 16'h0);
    bus0.data_rdy = 1'b1; bus0.data_read = 32'h7777_7777;
    tick();
    bus0.data_rdy = 1'b0;
    cs = 1'b1; addr = 18'h00010;
    tick();
    check("rm_refetch", bus0.sdram_req, 1'b1);

    // 6. OFFSET and top address
    cs1 = 1'b1; addr1 = 18'h3FFFF;
    tick();
    check("t6_req", bus1.sdram_req, 1'b1);
    check("t6_saddr", bus1.sdram_addr, 22'h13FFFE);
    bus1.sdram_ack = 1'b1; bus1.data_rdy = 1'b1; bus1.data_read = 32'hCAFE_0001;
    tick();
    bus1.sdram_ack = 1'b0; bus1.data_rdy = 1'b0;
    tick();
    check("t6_ok", ok1, 1'b1);
    check("t6_dout", dout1, 16'hCAFE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
